// File: rtl/conv_window_reg_if.sv
// Column-in / window-out handshake bundle for conv_window_reg.
//   master: column producer and window consumer (drives col_*, win_ready)
//   slave : the window register (drives col_ready, win_valid, window_out, fill_cnt)
// Signals:
//   col_valid, col_first, col_in  column stream from the producer
//   col_ready                     block accepts a column this cycle
//   win_valid, window_out         complete K x K window for the MAC stage
//   win_ready                     consumer takes the window this cycle
//   fill_cnt                      columns captured in the current row (saturates at K)
interface conv_window_reg_if #(
  parameter int unsigned PIX_W = 4,
  parameter int unsigned K     = 3
);
  logic                       col_valid;
  logic                       col_first;
  logic [K*PIX_W-1:0]         col_in;
  logic                       col_ready;
  logic                       win_valid;
  logic                       win_ready;
  logic [K*K*PIX_W-1:0]       window_out;
  logic [$clog2(K+1)-1:0]     fill_cnt;

  modport master (
    output col_valid, col_first, col_in, win_ready,
    input  col_ready, win_valid, window_out, fill_cnt
  );

  modport slave (
    input  col_valid, col_first, col_in, win_ready,
    output col_ready, win_valid, window_out, fill_cnt
  );
endinterface

// File: rtl/conv_window_reg.sv
// K x K sliding-window register for the convolver datapath.
// Accepts one K-pixel column per col handshake, shifts it into a K-column window and
// presents the full window to the MAC stage with its own valid/ready handshake.
// Ports:
//   clk    system clock, rising edge
//   n_rst  synchronous active-low reset
//   clear  synchronous flush of window and fill state (drops any presented column)
//   bus    conv_window_reg_if.slave: column in, window out, fill count
// Parameters:
//   PIX_W          bits per pixel
//   K              kernel dimension, 2..8
//   NEWEST_AT_LSB  1: newest column in slice 0; 0: newest column in the top slice
// Build option:
//   CONV_WIN_EDGE_PAD_EN  when defined, a col_first column is replicated into all K slots
//                         and the window is valid on the next cycle.
module conv_window_reg #(
  parameter int unsigned PIX_W         = 4,
  parameter int unsigned K             = 3,
  parameter bit          NEWEST_AT_LSB = 1'b1
) (
  input logic               clk,
  input logic               n_rst,
  input logic               clear,
  conv_window_reg_if.slave  bus
);

  localparam int unsigned CW = K * PIX_W;
  localparam int unsigned WW = K * CW;
  localparam int unsigned FW = $clog2(K + 1);

  logic [WW-1:0] win_q, win_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          valid_q, valid_d;
  logic          col_ready;
  logic          acc;
  logic          cons;
  logic [WW-1:0] shifted;

  // A column may enter in the same cycle the current window leaves.
  assign col_ready = ~clear & (~valid_q | bus.win_ready);
  assign acc       = bus.col_valid & col_ready;
  assign cons      = valid_q & bus.win_ready;

  always_comb begin
    shifted = win_q;
    if (NEWEST_AT_LSB) begin
      shifted = {win_q[WW-CW-1:0], bus.col_in};
    end else begin
      shifted = {bus.col_in, win_q[WW-1:CW]};
    end
  end

  always_comb begin
    win_d   = win_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    if (acc) begin
`ifdef CONV_WIN_EDGE_PAD_EN
      if (bus.col_first) begin
        // Replicate-edge padding: the first column fills every slot.
        win_d  = {K{bus.col_in}};
        fill_d = FW'(K);
      end else begin
        win_d  = shifted;
        fill_d = (fill_q >= FW'(K)) ? FW'(K) : fill_q + FW'(1);
      end
`else
      win_d = shifted;
      if (bus.col_first) begin
        // Stale columns from the previous row stay in the window but do not count.
        fill_d = FW'(1);
      end else begin
        fill_d = (fill_q >= FW'(K)) ? FW'(K) : fill_q + FW'(1);
      end
`endif
      valid_d = (fill_d == FW'(K));
    end else if (cons) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      win_q   <= '1;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      win_q   <= '1;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
    end
  end

  assign bus.col_ready  = col_ready;
  assign bus.win_valid  = valid_q;
  assign bus.window_out = win_q;
  assign bus.fill_cnt   = fill_q;

endmodule

// File: tb/tb_conv_window_reg.sv
// Self-checking bench for conv_window_reg (K=3, PIX_W=4).
// Two instances share all stimulus: one with newest column at the LSB end, one mirrored.
// A column-history model (newest first) predicts both windows, the fill count and the
// handshake; a constant table covers the directed sequences.
module tb_conv_window_reg;

  localparam int unsigned PIX_W = 4;
  localparam int unsigned K     = 3;
  localparam int unsigned CW    = K * PIX_W;
  localparam int unsigned WW    = K * CW;

  logic clk;
  logic n_rst;
  logic clear;

  conv_window_reg_if #(.PIX_W(PIX_W), .K(K)) bus_l ();
  conv_window_reg_if #(.PIX_W(PIX_W), .K(K)) bus_m ();

  conv_window_reg #(.PIX_W(PIX_W), .K(K), .NEWEST_AT_LSB(1'b1)) dut_l (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus_l.slave)
  );

  conv_window_reg #(.PIX_W(PIX_W), .K(K), .NEWEST_AT_LSB(1'b0)) dut_m (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus_m.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: history of the last K columns, index 0 = newest.
  logic [CW-1:0] m_cols [K];
  int            m_fill;
  bit            m_valid;

  typedef struct {
    bit            clr;
    bit            v;
    bit            f;
    logic [CW-1:0] col;
    bit            r;
    bit            exp_ready;
    logic [WW-1:0] exp_win_l;
    logic [WW-1:0] exp_win_m;
    bit            exp_valid;
    int            exp_fill;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] model_win(input bit lsb);
    logic [WW-1:0] w;
    for (int c = 0; c < K; c++) begin
      w[c*CW +: CW] = lsb ? m_cols[c] : m_cols[K-1-c];
    end
    return w;
  endfunction

  function automatic bit model_ready(input bit clr, input bit r);
    return !clr && (!m_valid || r);
  endfunction

  task automatic model_flush();
    for (int i = 0; i < K; i++) m_cols[i] = '1;
    m_fill  = 0;
    m_valid = 1'b0;
  endtask

  task automatic model_clock(input bit clr, input bit v, input bit f,
                             input logic [CW-1:0] col, input bit r);
    bit acc;
    bit cons;
    acc  = v && model_ready(clr, r);
    cons = m_valid && r;
    if (clr) begin
      model_flush();
    end else if (acc) begin
`ifdef CONV_WIN_EDGE_PAD_EN
      if (f) begin
        for (int i = 0; i < K; i++) m_cols[i] = col;
        m_fill = K;
      end else begin
        for (int i = K - 1; i > 0; i--) m_cols[i] = m_cols[i-1];
        m_cols[0] = col;
        m_fill = (m_fill + 1 > K) ? K : m_fill + 1;
      end
`else
      for (int i = K - 1; i > 0; i--) m_cols[i] = m_cols[i-1];
      m_cols[0] = col;
      m_fill = f ? 1 : ((m_fill + 1 > K) ? K : m_fill + 1);
`endif
      m_valid = (m_fill == K);
    end else if (cons) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic drive(input bit clr, input bit v, input bit f,
                       input logic [CW-1:0] col, input bit r);
    clear           = clr;
    bus_l.col_valid = v;
    bus_l.col_first = f;
    bus_l.col_in    = col;
    bus_l.win_ready = r;
    bus_m.col_valid = v;
    bus_m.col_first = f;
    bus_m.col_in    = col;
    bus_m.win_ready = r;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, " window_lsb"}, 64'(bus_l.window_out), 64'(model_win(1'b1)));
    chk({tag, " window_msb"}, 64'(bus_m.window_out), 64'(model_win(1'b0)));
    chk({tag, " win_valid"},  64'(bus_l.win_valid),  64'(m_valid));
    chk({tag, " fill_cnt"},   64'(bus_l.fill_cnt),   64'(m_fill));
    chk({tag, " valid_msb"},  64'(bus_m.win_valid),  64'(m_valid));
  endtask

  // Apply one cycle of inputs: check col_ready before the edge, registers after it.
  task automatic step(input bit clr, input bit v, input bit f,
                      input logic [CW-1:0] col, input bit r);
    drive(clr, v, f, col, r);
    #1;
    chk("col_ready", 64'(bus_l.col_ready), 64'(model_ready(clr, r)));
    chk("col_ready_msb", 64'(bus_m.col_ready), 64'(model_ready(clr, r)));
    @(posedge clk);
    model_clock(clr, v, f, col, r);
    #1;
    check_regs("step");
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    model_flush();
    #1;
    chk("reset window", 64'(bus_l.window_out), 64'h0000_000F_FFFF_FFFF);
    chk("reset valid", 64'(bus_l.win_valid), 64'd0);
    chk("reset fill", 64'(bus_l.fill_cnt), 64'd0);
    chk("reset col_ready", 64'(bus_l.col_ready), 64'd1);
    n_rst = 1'b1;
  endtask

  vec_t vecs [$];

  initial begin
    // Directed sequence: fill, backpressure, row restart, clear collision.
    vecs.push_back('{0, 1, 0, 12'h123, 1, 1, 36'hFFFFFF123, 36'h123FFFFFF, 0, 1});
    vecs.push_back('{0, 1, 0, 12'h456, 1, 1, 36'hFFF123456, 36'h456123FFF, 0, 2});
    vecs.push_back('{0, 1, 0, 12'h789, 1, 1, 36'h123456789, 36'h789456123, 1, 3});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{0, 1, 0, 12'hABC, 0, 0, 36'h123456789, 36'h789456123, 1, 3});
    vecs.push_back('{0, 1, 0, 12'hABC, 1, 1, 36'h456789ABC, 36'hABC789456, 1, 3});
    vecs.push_back('{0, 1, 1, 12'h111, 1, 1, 36'h789ABC111, 36'h111ABC789, 0, 1});
    vecs.push_back('{0, 1, 0, 12'h222, 1, 1, 36'hABC111222, 36'h222111ABC, 0, 2});
    vecs.push_back('{0, 1, 0, 12'h333, 1, 1, 36'h111222333, 36'h333222111, 1, 3});
    vecs.push_back('{1, 1, 0, 12'hFFF, 0, 0, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 0, 0});
    vecs.push_back('{0, 0, 0, 12'h000, 1, 1, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 0, 0});

    n_rst = 1'b0;
    model_flush();
    @(negedge clk);
    do_reset();

`ifndef CONV_WIN_EDGE_PAD_EN
    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].v, vecs[i].f, vecs[i].col, vecs[i].r);
      #1;
      chk($sformatf("vec%0d col_ready", i), 64'(bus_l.col_ready), 64'(vecs[i].exp_ready));
      @(posedge clk);
      model_clock(vecs[i].clr, vecs[i].v, vecs[i].f, vecs[i].col, vecs[i].r);
      #1;
      chk($sformatf("vec%0d window_lsb", i), 64'(bus_l.window_out), 64'(vecs[i].exp_win_l));
      chk($sformatf("vec%0d window_msb", i), 64'(bus_m.window_out), 64'(vecs[i].exp_win_m));
      chk($sformatf("vec%0d win_valid", i), 64'(bus_l.win_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d fill_cnt", i), 64'(bus_l.fill_cnt), 64'(vecs[i].exp_fill));
    end
`else
    // Edge padding: a row-start column fills the whole window at once.
    drive(1'b0, 1'b1, 1'b1, 12'h5A5, 1'b1);
    @(posedge clk);
    model_clock(1'b0, 1'b1, 1'b1, 12'h5A5, 1'b1);
    #1;
    chk("pad window", 64'(bus_l.window_out), 64'h0000_0005_A55A_55A5);
    chk("pad fill", 64'(bus_l.fill_cnt), 64'd3);
    chk("pad valid", 64'(bus_l.win_valid), 64'd1);
    // Row start while already full also replicates.
    step(1'b0, 1'b1, 1'b0, 12'h0C3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 12'h9E1, 1'b1);
    chk("pad refill", 64'(bus_l.window_out), 64'h0000_0009_E19E_19E1);
`endif

    // Sustained throughput: with win_ready high a window every cycle once filled.
    step(1'b0, 1'b1, 1'b1, 12'h0A1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, CW'(12'h100 + i), 1'b1);
    chk("stream valid", 64'(bus_l.win_valid), 64'd1);

    // Mid-row clear loses the partial fill.
    step(1'b0, 1'b1, 1'b1, 12'h321, 1'b1);
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1);
    chk("mid clear fill", 64'(bus_l.fill_cnt), 64'd0);

    // Randomized traffic against the model, with an occasional reset.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        do_reset();
      end else begin
        step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 5) == 0, CW'($urandom), $urandom_range(0, 2) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
